// File: rtl/fpadd_arbiter_if.sv
// Requester-side bundle for fpadd_arbiter: request operands in, tagged result out.
// Latency: none (wires only).
// Backpressure: req_valid held until req_ready; resp_valid is not backpressured.
interface fpadd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_sum;
    logic                  resp_err;

    // Requester side drives requests and observes grants/results.
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_id, resp_sum, resp_err
    );
endinterface

// File: rtl/fpadd_arbiter.sv
// Round-robin sharer of one fpadd unit among NUM_REQ requesters, with hang recovery.
// Latency: req_ready 1 cycle after grant; result 1 cycle after fpadd done; 2-cycle release before next grant.
// Backpressure: requesters hold req_valid until their req_ready pulse; responses are never stalled.
module fpadd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT     = 64,
    parameter int RECOVER_CYC = 2
) (
    input  logic           clk,
    input  logic           reset,
    fpadd_arbiter_if.slave req_if,
    output logic           busy,
    output logic           fpadd_start,
    output logic [31:0]    fpadd_a,
    output logic [31:0]    fpadd_b,
    output logic           fpadd_reset,
    input  logic [31:0]    fpadd_sum,
    input  logic           fpadd_done
);
    localparam int CW      = ID_W + 1;
    localparam int CNT_MAX = (TIMEOUT > RECOVER_CYC) ? TIMEOUT : RECOVER_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RELEASE,
        RECOVER
    } state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]    cur_id, cur_id_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_REQ-1:0] req_ready_nxt;
    logic               start_nxt;
    logic [31:0]        a_nxt, b_nxt;
    logic               resp_valid_nxt, resp_err_nxt;
    logic [ID_W-1:0]    resp_id_nxt;
    logic [31:0]        resp_sum_nxt;
    logic               busy_nxt;

    logic               win_vld;
    logic [ID_W-1:0]    win_id;
    logic [CW-1:0]      cand;
    logic [31:0]        a_sel, b_sel;

    // The adder is held in reset both by our own reset and while recovering from a hang.
    assign fpadd_reset = ~reset | (state == RECOVER);

    // Round-robin pick: scan rr_ptr+1 .. rr_ptr+NUM_REQ; the lowest offset with a request wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req_if.req_valid[j] && (cand == CW'(j))) begin
                    win_vld = 1'b1;
                    win_id  = ID_W'(j);
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_id == ID_W'(j)) begin
                a_sel = req_if.req_a[32*j +: 32];
                b_sel = req_if.req_b[32*j +: 32];
            end
        end
    end

    // Next-state and next-output logic; every output except fpadd_reset is registered from here.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        cur_id_nxt     = cur_id;
        cnt_nxt        = cnt;
        req_ready_nxt  = '0;
        start_nxt      = fpadd_start;
        a_nxt          = fpadd_a;
        b_nxt          = fpadd_b;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = req_if.resp_err;
        resp_id_nxt    = req_if.resp_id;
        resp_sum_nxt   = req_if.resp_sum;

        case (state)
            IDLE: begin
                if (win_vld) begin
                    a_nxt      = a_sel;
                    b_nxt      = b_sel;
                    cur_id_nxt = win_id;
                    rr_ptr_nxt = win_id;
                    start_nxt  = 1'b1;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        req_ready_nxt[j] = (win_id == ID_W'(j));
                    end
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_nxt = cnt + CNT_W'(1);
                // A done landing on the last allowed cycle still counts as success.
                if (fpadd_done) begin
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b0;
                    resp_id_nxt    = cur_id;
                    resp_sum_nxt   = fpadd_sum;
                    start_nxt      = 1'b0;
                    cnt_nxt        = '0;
                    state_nxt      = RELEASE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b1;
                    resp_id_nxt    = cur_id;
                    resp_sum_nxt   = QNAN;
                    start_nxt      = 1'b0;
                    cnt_nxt        = '0;
                    state_nxt      = RECOVER;
                end
            end
            RELEASE: begin
                // fpadd re-pulses done as it leaves its hold state; that pulse is swallowed here.
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            RECOVER: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(RECOVER_CYC - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                start_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            rr_ptr            <= ID_W'(NUM_REQ - 1);
            cur_id            <= '0;
            cnt               <= '0;
            req_if.req_ready  <= '0;
            req_if.resp_valid <= 1'b0;
            req_if.resp_err   <= 1'b0;
            req_if.resp_id    <= '0;
            req_if.resp_sum   <= '0;
            fpadd_start       <= 1'b0;
            fpadd_a           <= '0;
            fpadd_b           <= '0;
            busy              <= 1'b0;
        end else begin
            state             <= state_nxt;
            rr_ptr            <= rr_ptr_nxt;
            cur_id            <= cur_id_nxt;
            cnt               <= cnt_nxt;
            req_if.req_ready  <= req_ready_nxt;
            req_if.resp_valid <= resp_valid_nxt;
            req_if.resp_err   <= resp_err_nxt;
            req_if.resp_id    <= resp_id_nxt;
            req_if.resp_sum   <= resp_sum_nxt;
            fpadd_start       <= start_nxt;
            fpadd_a           <= a_nxt;
            fpadd_b           <= b_nxt;
            busy              <= busy_nxt;
        end
    end
endmodule
